fpu_issue_ctrl: RTL

Sequencer between the ID/EX stage and the single-ported fpu datapath. It accepts one FPU operation at a time, latches and holds the fpu operands for the op's latency, and waits on fpu_busy. It captures the result and presents it to writeback with a valid/ready handshake. It stalls the pipeline while the FPU is occupied and resolves dynamic rounding mode from the frm CSR.

---
 rtl/fpu_issue_ctrl_pkg.sv | 35 +++
 rtl/fpu_issue_ctrl.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/fpu_issue_ctrl_pkg.sv
// Shared types for the FPU issue sequencer: FSM states, dynamic rounding code,
// the func codes it needs from the core's ALU encoding, and the latency-class lookup.
package fpu_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_e;

    typedef enum logic {
        LAT_CLASS_ARITH = 1'b0,
        LAT_CLASS_CVT   = 1'b1
    } lat_class_e;

    localparam logic [2:0] RM_DYN = 3'b111;

    // Mirrors the ALU_* encoding used by the decoder.
    localparam logic [4:0] ALU_FADDS   = 5'h10;
    localparam logic [4:0] ALU_FSUBS   = 5'h11;
    localparam logic [4:0] ALU_FMULS   = 5'h12;
    localparam logic [4:0] ALU_FDIVS   = 5'h13;
    localparam logic [4:0] ALU_FCVTSW  = 5'h14;
    localparam logic [4:0] ALU_FCVTSWU = 5'h15;

    function automatic lat_class_e fpu_lat(input logic [4:0] func);
        lat_class_e cls;
        cls = LAT_CLASS_ARITH;
        if (func == ALU_FCVTSW || func == ALU_FCVTSWU) begin
            cls = LAT_CLASS_CVT;
        end
        return cls;
    endfunction

endpackage

// File: rtl/fpu_issue_ctrl.sv
// Single-op FPU sequencer: holds operands for the op latency plus fpu_busy, then
// offers the result to writeback. FPU_ISSUE_CTRL_PERF_EN adds op/stall counters.
module fpu_issue_ctrl
    import fpu_ctrl_pkg::*;
#(
    parameter int LAT_CVT   = 1,
    parameter int LAT_ARITH = 3,
    parameter int CNT_W     = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        issue_valid,
    input  logic [4:0]  issue_func,
    input  logic [2:0]  issue_rm,
    input  logic [31:0] issue_opa,
    input  logic [31:0] issue_opb,
    input  logic [4:0]  issue_dest,
    input  logic [2:0]  frm_csr,
    input  logic        flush,
    output logic        issue_ready,
    output logic        stall,
    output logic [31:0] fpu_opa,
    output logic [31:0] fpu_opb,
    output logic [4:0]  fpu_func,
    output logic [2:0]  fpu_rm,
    input  logic [31:0] fpu_res,
    input  logic        fpu_busy,
    output logic        wb_valid,
    output logic [31:0] wb_data,
    output logic [4:0]  wb_dest,
    input  logic        wb_ready
`ifdef FPU_ISSUE_CTRL_PERF_EN
    ,
    output logic [31:0] perf_ops,
    output logic [31:0] perf_stall_cycles
`endif
);

    state_e             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   cnt_d;
    logic [31:0]        fpu_opa_q;
    logic [31:0]        fpu_opb_q;
    logic [4:0]         fpu_func_q;
    logic [2:0]         fpu_rm_q;
    logic [2:0]         fpu_rm_d;
    logic [4:0]         dest_q;
    logic               wb_valid_q;
    logic [31:0]        wb_data_q;
    logic [4:0]         wb_dest_q;
    logic               accept;

    assign issue_ready = (state_q == IDLE) || (state_q == DONE && wb_ready);
    assign stall       = issue_valid && !issue_ready;
    assign accept      = issue_valid && issue_ready && !flush;

    // frm is only consulted here, so a CSR write mid-op cannot disturb the held op.
    always_comb begin
        fpu_rm_d = (issue_rm == RM_DYN) ? frm_csr : issue_rm;
        cnt_d    = (fpu_lat(issue_func) == LAT_CLASS_CVT) ? CNT_W'(LAT_CVT - 1)
                                                          : CNT_W'(LAT_ARITH - 1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            fpu_opa_q  <= '0;
            fpu_opb_q  <= '0;
            fpu_func_q <= '0;
            fpu_rm_q   <= '0;
            dest_q     <= '0;
            wb_valid_q <= 1'b0;
            wb_data_q  <= '0;
            wb_dest_q  <= '0;
        end else if (flush) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            wb_valid_q <= 1'b0;
        end else begin
            if (accept) begin
                fpu_opa_q  <= issue_opa;
                fpu_opb_q  <= issue_opb;
                fpu_func_q <= issue_func;
                fpu_rm_q   <= fpu_rm_d;
                dest_q     <= issue_dest;
                cnt_q      <= cnt_d;
                state_q    <= EXEC;
            end
            case (state_q)
                EXEC: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end else if (!fpu_busy) begin
                        wb_data_q  <= fpu_res;
                        wb_dest_q  <= dest_q;
                        wb_valid_q <= 1'b1;
                        state_q    <= DONE;
                    end
                end
                DONE: begin
                    // A same-cycle accept already moved us to EXEC above.
                    if (wb_ready) begin
                        wb_valid_q <= 1'b0;
                        if (!accept) begin
                            state_q <= IDLE;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign fpu_opa  = fpu_opa_q;
    assign fpu_opb  = fpu_opb_q;
    assign fpu_func = fpu_func_q;
    assign fpu_rm   = fpu_rm_q;
    assign wb_valid = wb_valid_q;
    assign wb_data  = wb_data_q;
    assign wb_dest  = wb_dest_q;

`ifdef FPU_ISSUE_CTRL_PERF_EN
    logic [31:0] perf_ops_q;
    logic [31:0] perf_stall_q;
    logic        wb_handshake;

    // A flushed result never counts as delivered.
    assign wb_handshake = (state_q == DONE) && wb_ready && !flush;

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_ops_q   <= '0;
            perf_stall_q <= '0;
        end else begin
            if (wb_handshake && perf_ops_q != 32'hFFFF_FFFF) begin
                perf_ops_q <= perf_ops_q + 32'd1;
            end
            if (stall && perf_stall_q != 32'hFFFF_FFFF) begin
                perf_stall_q <= perf_stall_q + 32'd1;
            end
        end
    end

    assign perf_ops          = perf_ops_q;
    assign perf_stall_cycles = perf_stall_q;
`endif

endmodule
